// File: rtl/huff_pkg.sv
// Shared constants, state encoding and chunk payload for the Huffman bit unpacker.
package huff_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CHUNK_W = 4;
  localparam int unsigned BUF_W   = 2 * BYTE_W;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned LEN_W   = 3;
  localparam int unsigned LB_W    = 4;

  typedef enum logic [1:0] {
    S_STREAM = 2'd0,
    S_DRAIN  = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic [CHUNK_W-1:0] data;
    logic [LEN_W-1:0]   len;
    logic               last;
  } chunk_t;

  function automatic logic [CNT_W-1:0] min_cnt(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/huff_bit_unpacker.sv
// Re-slices an MSB-first byte stream into 1-4 bit chunks for the Huffman decoder.
module huff_bit_unpacker
  import huff_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [BYTE_W-1:0]  s_byte,
  input  logic               s_byte_valid,
  output logic               s_byte_ready,
  input  logic               s_last,
  input  logic [LB_W-1:0]    s_last_bits,
  output logic               svalid,
  output logic [CHUNK_W-1:0] in_data,
  output logic [LEN_W-1:0]   in_len,
  input  logic               aready,
  output logic               chunk_last,
  output logic               done
);

  state_t             state, state_nx;
  logic [BUF_W-1:0]   bits, bits_nx;
  logic [CNT_W-1:0]   count, count_nx;
  logic               last_seen, last_seen_nx;
  chunk_t             chunk, chunk_nx;
  logic               svalid_nx;
  logic               done_nx;

  logic               accept;
  logic               xfer;
  logic               chunk_rdy;
  logic               load;
  logic [CNT_W-1:0]   take;
  logic [CNT_W-1:0]   app_len;
  logic [CNT_W-1:0]   rem_cnt;
  logic [BUF_W-1:0]   rem_bits;
  logic [BUF_W-1:0]   app_ext;
  logic [BYTE_W-1:0]  byte_mask;
  logic [CHUNK_W-1:0] top;

  // Ready depends only on registered state so the byte source sees no comb loop.
  assign s_byte_ready = (count <= CNT_W'(BYTE_W)) && !last_seen && (state == S_STREAM);
  assign in_data      = chunk.data;
  assign in_len       = chunk.len;
  assign chunk_last   = chunk.last;

  always_comb begin
    state_nx     = state;
    bits_nx      = bits;
    count_nx     = count;
    last_seen_nx = last_seen;
    chunk_nx     = chunk;
    svalid_nx    = svalid;
    done_nx      = 1'b0;

    accept    = s_byte_valid && s_byte_ready;
    xfer      = svalid && aready;
    chunk_rdy = (count >= CNT_W'(CHUNK_W)) || (last_seen && (count != '0));
    load      = chunk_rdy && (!svalid || aready);
    take      = load ? min_cnt(count, CNT_W'(CHUNK_W)) : '0;

    if (s_last && (s_last_bits != '0) && (s_last_bits < LB_W'(BYTE_W)))
      app_len = CNT_W'(s_last_bits);
    else
      app_len = CNT_W'(BYTE_W);

    // Trailing pad bits of a partial final byte are masked off before appending.
    byte_mask = BYTE_W'(8'hFF << (CNT_W'(BYTE_W) - app_len));
    rem_cnt   = count - take;
    rem_bits  = bits << take;
    app_ext   = {s_byte & byte_mask, BYTE_W'(0)} >> rem_cnt;
    top       = bits[BUF_W-1 -: CHUNK_W];

    if (load) begin
      svalid_nx     = 1'b1;
      chunk_nx.data = CHUNK_W'(top >> (CNT_W'(CHUNK_W) - take));
      chunk_nx.len  = LEN_W'(take);
      chunk_nx.last = last_seen && (rem_cnt == '0);
    end else if (xfer) begin
      svalid_nx = 1'b0;
      chunk_nx  = '0;
    end

    bits_nx  = accept ? (rem_bits | app_ext) : rem_bits;
    count_nx = accept ? (rem_cnt + app_len) : rem_cnt;

    case (state)
      S_STREAM: begin
        if (accept && s_last) begin
          last_seen_nx = 1'b1;
          state_nx     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (xfer && chunk.last) begin
          state_nx = S_DONE;
          done_nx  = 1'b1;
        end
      end
      S_DONE: begin
        last_seen_nx = 1'b0;
        state_nx     = S_STREAM;
      end
      default: state_nx = S_STREAM;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_STREAM;
      bits      <= '0;
      count     <= '0;
      last_seen <= 1'b0;
      chunk     <= '0;
      svalid    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      bits      <= bits_nx;
      count     <= count_nx;
      last_seen <= last_seen_nx;
      chunk     <= chunk_nx;
      svalid    <= svalid_nx;
      done      <= done_nx;
    end
  end

endmodule

// File: tb/tb_huff_bit_unpacker.sv
// Directed table-driven bench for huff_bit_unpacker with hand-computed chunk streams.
module tb_huff_bit_unpacker;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] s_byte;
  logic       s_byte_valid;
  logic       s_byte_ready;
  logic       s_last;
  logic [3:0] s_last_bits;
  logic       svalid;
  logic [3:0] in_data;
  logic [2:0] in_len;
  logic       aready;
  logic       chunk_last;
  logic       done;

  int tests = 0;
  int fails = 0;

  huff_bit_unpacker dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_byte       (s_byte),
    .s_byte_valid (s_byte_valid),
    .s_byte_ready (s_byte_ready),
    .s_last       (s_last),
    .s_last_bits  (s_last_bits),
    .svalid       (svalid),
    .in_data      (in_data),
    .in_len       (in_len),
    .aready       (aready),
    .chunk_last   (chunk_last),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] bytes;     // byte 0 at [31:24]
    int          nbytes;
    logic [3:0]  last_bits;
    int          hold;      // cycles of aready=0 at start
    int          nchunks;
    logic [31:0] exp_data;  // chunk i at [31-4i -: 4]
    logic [23:0] exp_len;   // chunk i at [23-3i -: 3]
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int bi = 0;
    int ci = 0;
    int cyc = 0;
    int first = -1;
    int lastx = -1;
    bit have_hold = 0;
    logic [7:0] held;
    bit acc;
    bit xf;
    while (ci < v.nchunks && cyc < 300) begin
      @(negedge clk);
      aready       = (cyc >= v.hold);
      s_byte_valid = (bi < v.nbytes);
      s_byte       = (bi < v.nbytes) ? v.bytes[31-8*bi -: 8] : 8'h00;
      s_last       = (bi == v.nbytes - 1);
      s_last_bits  = v.last_bits;
      if (!aready && svalid) begin
        if (!have_hold) begin
          held = {in_len, in_data, chunk_last};
          have_hold = 1;
        end else
          check($sformatf("v%0d hold stable c%0d", id, cyc), 32'({in_len, in_data, chunk_last}), 32'(held));
      end
      if (v.hold > 0 && cyc == v.hold - 1)
        check($sformatf("v%0d ready low under backpressure", id), 32'(s_byte_ready), 32'd0);
      acc = s_byte_valid && s_byte_ready;
      xf  = svalid && aready;
      if (xf) begin
        check($sformatf("v%0d chunk%0d data", id, ci), 32'(in_data), 32'(v.exp_data[31-4*ci -: 4]));
        check($sformatf("v%0d chunk%0d len", id, ci), 32'(in_len), 32'(v.exp_len[23-3*ci -: 3]));
        check($sformatf("v%0d chunk%0d last", id, ci), 32'(chunk_last), 32'(ci == v.nchunks - 1));
        if (first < 0) first = cyc;
        lastx = cyc;
        ci++;
      end
      @(posedge clk);
      if (acc) bi++;
      cyc++;
    end
    check($sformatf("v%0d chunk count", id), 32'(ci), 32'(v.nchunks));
    @(negedge clk);
    s_byte_valid = 1'b0;
    check($sformatf("v%0d done pulse", id), 32'(done), 32'd1);
    @(negedge clk);
    check($sformatf("v%0d done cleared", id), 32'(done), 32'd0);
    check($sformatf("v%0d svalid idle", id), 32'(svalid), 32'd0);
    if (v.hold == 0)
      check($sformatf("v%0d no bubbles", id), 32'(lastx - first), 32'(v.nchunks - 1));
  endtask

  initial begin
    vecs[0] = '{32'hB46C_0000, 2, 4'd8, 0, 4, 32'hB46C_0000, {3'd4, 3'd4, 3'd4, 3'd4, 12'd0}};
    vecs[1] = '{32'hE000_0000, 1, 4'd3, 0, 1, 32'h7000_0000, {3'd3, 21'd0}};
    vecs[2] = '{32'hF400_0000, 1, 4'd6, 0, 2, 32'hF100_0000, {3'd4, 3'd2, 18'd0}};
    vecs[3] = '{32'hA500_0000, 1, 4'd0, 0, 2, 32'hA500_0000, {3'd4, 3'd4, 18'd0}};
    vecs[4] = '{32'h1234_5600, 3, 4'd5, 0, 6, 32'h1234_5000,
                {3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd1, 6'd0}};
    vecs[5] = '{32'h8000_0000, 1, 4'd1, 0, 1, 32'h1000_0000, {3'd1, 21'd0}};
    vecs[6] = '{32'hC300_0000, 1, 4'd7, 0, 2, 32'hC100_0000, {3'd4, 3'd3, 18'd0}};
    vecs[7] = '{32'h3C99_5AF0, 4, 4'd8, 6, 8, 32'h3C99_5AF0,
                {3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4}};

    reset_n      = 1'b0;
    s_byte       = 8'h00;
    s_byte_valid = 1'b0;
    s_last       = 1'b0;
    s_last_bits  = 4'd0;
    aready       = 1'b0;
    repeat (2) @(negedge clk);
    check("reset svalid", 32'(svalid), 32'd0);
    check("reset in_data", 32'(in_data), 32'd0);
    check("reset in_len", 32'(in_len), 32'd0);
    check("reset chunk_last", 32'(chunk_last), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset ready", 32'(s_byte_ready), 32'd1);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Mid-stream asynchronous reset with buffered bits and a pending chunk.
    @(negedge clk);
    aready = 1'b0; s_byte_valid = 1'b1; s_byte = 8'h12; s_last = 1'b0;
    @(negedge clk);
    s_byte = 8'h34;
    @(negedge clk);
    s_byte_valid = 1'b0;
    check("midrst svalid before", 32'(svalid), 32'd1);
    check("midrst data before", 32'(in_data), 32'h1);
    reset_n = 1'b0;
    #1;
    check("midrst svalid async clear", 32'(svalid), 32'd0);
    check("midrst in_len clear", 32'(in_len), 32'd0);
    check("midrst ready", 32'(s_byte_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    run_vec(8, vecs[3]);

    // Empty stream: nothing offered, no chunk must appear.
    aready = 1'b1;
    repeat (10) @(negedge clk);
    check("empty svalid", 32'(svalid), 32'd0);
    check("empty done", 32'(done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
